// File: rtl/cuenta_pkg.sv
// Shared definitions for the round-robin scheduler in front of the shared cuenta1 counter.
package cuenta_pkg;

    localparam int W_VALOR_DEF = 3;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [1:0] {
        LIBRE    = 2'd0,
        ARRANQUE = 2'd1,
        ESPERA   = 2'd2,
        FIN      = 2'd3
    } estado_t;

    typedef enum logic {
        OK  = 1'b0,
        TMO = 1'b1
    } motivo_t;

endpackage

// File: rtl/rr_sel4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping upward.
module rr_sel4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valido
);

    logic [1:0] cand;

    // Scan from the farthest candidate down so the closest one to ptr wins.
    always_comb begin
        idx    = ptr;
        valido = |req;
        cand   = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/planificador_cuenta.sv
// Shares one counter among four requesters: grants round-robin, pulses start, waits for fin
// or a timeout, then reports completion (hecho) or abort (err) for the served requester.
module planificador_cuenta
    import cuenta_pkg::*;
#(
    parameter int W_VALOR = W_VALOR_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           req,
    input  logic [4*W_VALOR-1:0] valores,
    input  logic                 fin,
    output logic                 start,
    output logic [W_VALOR-1:0]   valor,
    output logic [3:0]           gnt,
    output logic                 ocupado,
    output logic [3:0]           hecho,
    output logic                 err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    estado_t            estado_q, estado_d;
    motivo_t            motivo_q, motivo_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         gidx_q, gidx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [W_VALOR-1:0] valor_q, valor_d;
    logic [3:0]         gnt_q, gnt_d;
    logic               start_q, start_d;

    logic [1:0]         sel_idx;
    logic               sel_valido;

    rr_sel4 u_sel (
        .req    (req),
        .ptr    (ptr_q),
        .idx    (sel_idx),
        .valido (sel_valido)
    );

    always_comb begin
        estado_d = estado_q;
        motivo_d = motivo_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        tmo_d    = tmo_q;
        valor_d  = valor_q;
        gnt_d    = gnt_q;
        start_d  = 1'b0;
        case (estado_q)
            LIBRE: begin
                if (sel_valido) begin
                    estado_d = ARRANQUE;
                    gidx_d   = sel_idx;
                    gnt_d    = 4'b0001 << sel_idx;
                    valor_d  = valores[sel_idx*W_VALOR +: W_VALOR];
                    start_d  = 1'b1;
                end
            end
            ARRANQUE: begin
                estado_d = ESPERA;
                tmo_d    = '0;
                ptr_d    = gidx_q + 2'd1;
            end
            ESPERA: begin
                // fin has priority over a timeout landing on the same cycle.
                if (fin) begin
                    estado_d = FIN;
                    motivo_d = OK;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    estado_d = FIN;
                    motivo_d = TMO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FIN: begin
                estado_d = LIBRE;
                gnt_d    = '0;
            end
            default: estado_d = LIBRE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= LIBRE;
            motivo_q <= OK;
            ptr_q    <= '0;
            gidx_q   <= '0;
            tmo_q    <= '0;
            valor_q  <= '0;
            gnt_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            motivo_q <= motivo_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            tmo_q    <= tmo_d;
            valor_q  <= valor_d;
            gnt_q    <= gnt_d;
            start_q  <= start_d;
        end
    end

    assign start   = start_q;
    assign valor   = valor_q;
    assign gnt     = gnt_q;
    assign ocupado = (estado_q != LIBRE);
    assign hecho   = (estado_q == FIN && motivo_q == OK)  ? gnt_q : 4'b0000;
    assign err     = (estado_q == FIN && motivo_q == TMO);

endmodule

// File: tb/tb_planificador_cuenta.sv
// Bench for planificador_cuenta: scenario tasks checked against a transaction-level model.
module tb_planificador_cuenta;

    localparam int WV = 3;
    localparam int TO = 31;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      req = '0;
    logic [4*WV-1:0] valores = '0;
    logic            fin = 1'b0;
    logic            start;
    logic [WV-1:0]   valor;
    logic [3:0]      gnt;
    logic            ocupado;
    logic [3:0]      hecho;
    logic            err;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    planificador_cuenta #(.W_VALOR(WV), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .valores (valores),
        .fin     (fin),
        .start   (start),
        .valor   (valor),
        .gnt     (gnt),
        .ocupado (ocupado),
        .hecho   (hecho),
        .err     (err)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    // One full transaction from LIBRE back to LIBRE; fin_dly >= TO means fin never comes.
    task automatic serve_one(input string tag, input logic [3:0] r, input logic [4*WV-1:0] v,
                             input logic [3:0] r_after, input logic [4*WV-1:0] v_after,
                             input int fin_dly);
        int g;
        int last;
        logic [3:0] eg;
        logic [WV-1:0] ev;
        g  = pick(r, m_ptr);
        eg = 4'b0001 << g;
        ev = v[g*WV +: WV];
        req = r;
        valores = v;
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || gnt !== eg || valor !== ev || ocupado !== 1'b1 || hecho !== 4'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s grant: got start=%b gnt=%b valor=%0d ocupado=%b hecho=%b err=%b, want start=1 gnt=%b valor=%0d ocupado=1 hecho=0000 err=0",
                     tag, start, gnt, valor, ocupado, hecho, err, eg, ev);
        end
        m_ptr = (g + 1) % 4;
        req = r_after;
        valores = v_after;
        last = (fin_dly < TO) ? fin_dly : TO - 1;
        for (int e = 0; e <= last; e++) begin
            @(negedge clk);
            checks++;
            if (start !== 1'b0 || gnt !== eg || valor !== ev || ocupado !== 1'b1 || hecho !== 4'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL %s wait%0d: got start=%b gnt=%b valor=%0d ocupado=%b hecho=%b err=%b, want start=0 gnt=%b valor=%0d ocupado=1 hecho=0000 err=0",
                         tag, e, start, gnt, valor, ocupado, hecho, err, eg, ev);
            end
            fin = (e == fin_dly);
        end
        @(negedge clk);
        fin = 1'b0;
        checks++;
        if (fin_dly < TO) begin
            if (hecho !== eg || err !== 1'b0 || gnt !== eg || ocupado !== 1'b1 || start !== 1'b0 || valor !== ev) begin
                errors++;
                $display("FAIL %s done: got hecho=%b err=%b gnt=%b ocupado=%b start=%b valor=%0d, want hecho=%b err=0 gnt=%b ocupado=1 start=0 valor=%0d",
                         tag, hecho, err, gnt, ocupado, start, valor, eg, eg, ev);
            end
        end else begin
            if (hecho !== 4'b0 || err !== 1'b1 || gnt !== eg || ocupado !== 1'b1 || start !== 1'b0 || valor !== ev) begin
                errors++;
                $display("FAIL %s timeout: got hecho=%b err=%b gnt=%b ocupado=%b start=%b valor=%0d, want hecho=0000 err=1 gnt=%b ocupado=1 start=0 valor=%0d",
                         tag, hecho, err, gnt, ocupado, start, valor, eg, ev);
            end
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || gnt !== 4'b0 || ocupado !== 1'b0 || hecho !== 4'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got start=%b gnt=%b ocupado=%b hecho=%b err=%b, want all zero",
                     tag, start, gnt, ocupado, hecho, err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({start, valor, gnt, ocupado, hecho, err} !== '0) begin
            errors++;
            $display("FAIL reset: got start=%b valor=%0d gnt=%b ocupado=%b hecho=%b err=%b, want all zero",
                     start, valor, gnt, ocupado, hecho, err);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++)
            serve_one("round_robin", 4'hF, 12'($urandom), 4'hF, 12'($urandom), 0);
    endtask

    task automatic test_single();
        serve_one("single", 4'b0001, 12'h005, 4'b0000, 12'h005, 5);
    endtask

    task automatic test_timeout();
        serve_one("timeout", 4'b0100, 12'($urandom), 4'b0100, 12'($urandom), TO + 5);
    endtask

    task automatic test_simultaneous();
        serve_one("fin_at_tmo", 4'b1000, 12'($urandom), 4'b0000, 12'($urandom), TO - 1);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            fin = (i != 1);
            @(negedge clk);
            checks++;
            if (start !== 1'b0 || gnt !== 4'b0 || ocupado !== 1'b0 || hecho !== 4'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL fin_in_idle: got start=%b gnt=%b ocupado=%b hecho=%b err=%b, want all zero",
                         start, gnt, ocupado, hecho, err);
            end
        end
        fin = 1'b0;
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        valores = 12'o5432;
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || gnt !== 4'b0100 || valor !== 3'd4) begin
            errors++;
            $display("FAIL reset_mid grant: got start=%b gnt=%b valor=%0d, want start=1 gnt=0100 valor=4", start, gnt, valor);
        end
        req = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({start, valor, gnt, ocupado, hecho, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid async: got start=%b valor=%0d gnt=%b ocupado=%b hecho=%b err=%b, want all zero",
                     start, valor, gnt, ocupado, hecho, err);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({start, valor, gnt, ocupado, hecho, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid held: got start=%b valor=%0d gnt=%b ocupado=%b hecho=%b err=%b, want all zero",
                     start, valor, gnt, ocupado, hecho, err);
        end
        reset_n = 1'b1;
        m_ptr = 0;
        fin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (hecho !== 4'b0 || err !== 1'b0 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid stale: got hecho=%b err=%b ocupado=%b, want 0000 0 0", hecho, err, ocupado);
            end
        end
        fin = 1'b0;
        serve_one("after_reset", 4'b1010, 12'($urandom), 4'b0000, 12'($urandom), 2);
    endtask

    task automatic test_value_stable();
        logic [4*WV-1:0] v;
        logic [4*WV-1:0] v2;
        v  = 12'($urandom);
        v[5:3] = 3'd3;
        v2 = v;
        v2[5:3] = 3'd7;
        serve_one("value_stable", 4'b0010, v, 4'b0010, v2, 4);
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 5))
                0:       d = TO - 1;
                1:       d = TO + 2;
                default: d = $urandom_range(0, 6);
            endcase
            serve_one("random", 4'($urandom_range(1, 15)), 12'($urandom),
                      4'($urandom), 12'($urandom), d);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_value_stable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
